// File: rtl/dot_product_accumulator_if.sv
// Operand-stream and result handshake bundle for dot_product_accumulator.
interface dot_product_accumulator_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow
    );
endinterface

// File: rtl/dot_product_accumulator.sv
// Streaming saturating multiply-accumulate: sums a*b over a vector delimited by in_last,
// then holds one registered result until the consumer takes it.
module Multiplier (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    assign p = 16'(a) * 16'(b);
endmodule

module dot_product_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input logic                     clk,
    input logic                     rst,
    dot_product_accumulator_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             ready_q;
    logic             valid_q;
    logic [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    logic [15:0]      prod;
    logic [ACC_W:0]   sum_w;
    logic [CNT_W:0]   cnt_w;
    logic             sat_add;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;

    Multiplier u_mul (.a(bus.in_a), .b(bus.in_b), .p(prod));

    // One extra bit catches the carry out; it doubles as the saturation flag.
    assign sum_w   = {1'b0, acc} + {{(ACC_W+1-16){1'b0}}, prod};
    assign sat_add = sum_w[ACC_W];
    assign acc_nxt = sat_add ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
    assign cnt_w   = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_nxt = cnt_w[CNT_W] ? {CNT_W{1'b1}} : cnt_w[CNT_W-1:0];
    assign accept  = (state == ACCUM) && ready_q && bus.in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (bus.in_last) begin
                            sum_q   <= acc_nxt;
                            count_q <= cnt_nxt;
                            ovf_q   <= ovf | sat_add;
                            acc     <= '0;
                            cnt     <= '0;
                            ovf     <= 1'b0;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                            state   <= HOLD;
                        end else begin
                            acc <= acc_nxt;
                            cnt <= cnt_nxt;
                            ovf <= ovf | sat_add;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready     = ready_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_sum      = sum_q;
    assign bus.out_count    = count_q;
    assign bus.out_overflow = ovf_q;
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator; inputs change and outputs are sampled 1ns after rising edges.
module tb_dot_product_accumulator;
    localparam int ACC_W = 24;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    dot_product_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    dot_product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until it is accepted (bounded).
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        for (int i = 0; i < 20 && !done; i++) begin
            done = bus.in_ready;
            step();
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_last  = 1'b0;
    endtask

    task automatic result(input string tag, input logic [31:0] sum, input logic [31:0] cnt,
                          input logic ovf);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(bus.out_sum), sum);
        chk({tag, "_count"}, 32'(bus.out_count), cnt);
        chk({tag, "_ovf"}, 32'(bus.out_overflow), 32'(ovf));
        chk({tag, "_ready_low"}, 32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        idle();
        bus.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        step();
        step();
        rst = 1'b0;
        chk("rst_release_ready_low", 32'(bus.in_ready), 32'd0);
        step();
        chk("ready_after_release", 32'(bus.in_ready), 32'd1);

        // Single max beat, vector of length 1
        beat(8'd255, 8'd255, 1'b1);
        idle();
        result("single", 32'd65025, 32'd1, 1'b0);
        step();
        chk("single_valid_drop", 32'(bus.out_valid), 32'd0);
        chk("single_ready_back", 32'(bus.in_ready), 32'd1);

        // Three back-to-back beats
        beat(8'd1, 8'd2, 1'b0);
        beat(8'd3, 8'd4, 1'b0);
        beat(8'd5, 8'd6, 1'b1);
        idle();
        result("three", 32'd44, 32'd3, 1'b0);
        step();
        chk("three_valid_one_cycle", 32'(bus.out_valid), 32'd0);

        // Backpressure: HOLD ignores offered beats and keeps the result
        bus.out_ready = 1'b0;
        beat(8'd1, 8'd2, 1'b0);
        beat(8'd3, 8'd4, 1'b0);
        beat(8'd5, 8'd6, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'd9;
        bus.in_b     = 8'd9;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_ready_low", 32'(bus.in_ready), 32'd0);
            chk("hold_sum", 32'(bus.out_sum), 32'd44);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        chk("hold_release_ready", 32'(bus.in_ready), 32'd1);
        beat(8'd9, 8'd9, 1'b1);
        idle();
        result("after_hold", 32'd81, 32'd1, 1'b0);
        step();

        // Saturation: 259*65025 exceeds 2^24-1, count caps at 255
        for (int i = 1; i <= 300; i++) begin
            beat(8'd255, 8'd255, (i == 300));
            if (i == 258) chk("sat_not_yet_258", 32'(dut.ovf), 32'd0);
            if (i == 259) chk("sat_at_259", 32'(dut.ovf), 32'd1);
        end
        idle();
        result("sat", 32'd16777215, 32'd255, 1'b1);
        step();
        beat(8'd2, 8'd3, 1'b1);
        idle();
        result("post_sat", 32'd6, 32'd1, 1'b0);
        step();

        // Reset mid-vector discards the partial sum
        beat(8'd100, 8'd100, 1'b0);
        beat(8'd50, 8'd50, 1'b0);
        idle();
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_sum", 32'(bus.out_sum), 32'd0);
        chk("midrst_count", 32'(bus.out_count), 32'd0);
        chk("midrst_ovf", 32'(bus.out_overflow), 32'd0);
        step();
        step();
        chk("midrst_ready_held", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        beat(8'd10, 8'd10, 1'b1);
        idle();
        result("post_rst", 32'd100, 32'd1, 1'b0);
        step();

        // Zero-valued beats count; idle cycles change nothing
        beat(8'd0, 8'd200, 1'b0);
        idle();
        step();
        step();
        step();
        beat(8'd7, 8'd0, 1'b0);
        beat(8'd4, 8'd5, 1'b1);
        idle();
        result("zeros", 32'd20, 32'd3, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Streaming multiply-accumulate stage built around the existing combinational 8x8 unsigned `Multiplier`. It accepts a vector of operand pairs over a valid/ready handshake and forms each product with an internal `Multiplier` instance. It sums the products into a saturating accumulator and emits one result per vector, marked by `in_last`. It sits directly downstream of the multiplier and is the first clocked stage of the datapath.

## Interface

- `ACC_W`, 24: accumulator and result width in bits; must be ≥ 16.
- `CNT_W`, 8: beat-counter width in bits.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_a`  in  8  unsigned operand A.
- `in_b`  in  8  unsigned operand B.
- `in_last`  in  1  beat is the final one of the vector.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  ACC_W  saturated sum of products.
- `out_count`  out  CNT_W  number of beats in the vector, saturating.
- `out_overflow`  out  1  the sum saturated during the vector.

## Operation

- Product: `in_a`/`in_b` drive a `Multiplier` instance (ports `a`, `b`, `p`). `p` is 16-bit, zero-extended to ACC_W.
- Beat accepted when `in_valid && in_ready` at a rising edge.
- The FSM has two states: ACCUM and HOLD.
- ACCUM:
  - `in_ready`=1 and `out_valid`=0.
  - On an accepted beat with `in_last`=0: `acc <= sat(acc + p)`, `cnt <= sat(cnt + 1)`, and `ovf` is set if the add saturated.
  - On an accepted beat with `in_last`=1: the same update goes into the output registers instead. `out_sum <= sat(acc + p)`, `out_count <= sat(cnt + 1)`, and `out_overflow <= ovf | saturated-this-beat`.
  - `acc`, `cnt` and `ovf` clear to 0 and the FSM goes to HOLD.
- HOLD:
  - `in_ready`=0 and `out_valid`=1. `in_valid` and all `in_*` are ignored.
  - On `out_ready`=1 the FSM goes to ACCUM. Outputs keep their last values but are qualified only by `out_valid`.
- Arithmetic:
  - Sum computed at ACC_W+1 bits. If bit ACC_W is set, the result is 2^ACC_W−1 and the saturation flag is set.
  - Once saturated, further adds keep the result at all ones.
  - Count saturates at 2^CNT_W−1 and raises no flag.
- Beats of zero value (a=0 or b=0) are counted normally.
- Idle cycles (`in_valid`=0) in ACCUM leave all state unchanged.
- A vector of length 1 is legal: the first beat has `in_last`=1.

## Timing

- Reset values while `rst` is high, taking effect immediately:
  - State ACCUM; `acc`, `cnt`, `ovf` = 0.
  - `out_valid`=0, `out_sum`=0, `out_count`=0, `out_overflow`=0.
  - `in_ready`=0.
- `in_ready`=1 from the first rising edge after `rst` deasserts.
- Throughput: one beat per cycle in ACCUM, with no bubble between non-last beats.
- Latency: a last beat accepted at edge N gives `out_valid`=1 immediately after edge N.
- If `out_ready`=1 at edge N+1, `out_valid` drops and `in_ready` rises after that edge. Minimum vector-to-vector gap is one non-accepting cycle.
- `in_ready` depends only on state. It never depends combinationally on `in_valid` or `out_ready`.
- `out_*` are registered and stable for the whole HOLD interval.
- Reset mid-vector or in HOLD:
  - The partial sum and any pending result are discarded without emission.
  - The first vector after release starts from zero.

## Test plan

- Single beat a=255, b=255, last=1 → `out_sum`=65025, `out_count`=1, `out_overflow`=0, `out_valid` one cycle after the accept edge.
- Beats (1,2), (3,4), (5,6,last) on consecutive cycles, `out_ready`=1 → `out_sum`=44, `out_count`=3, `out_valid` high exactly one cycle.
- Same three-beat vector with `out_ready` held 0 for 5 cycles while `in_valid`=1 with (9,9) → `in_ready`=0 throughout and result stable at 44. After `out_ready`, the next vector (9,9,last) gives 81, not 81 + 44.
- 300 beats of (255,255), last on beat 300 →
  - Saturation occurs at beat 259.
  - `out_sum`=16777215, `out_overflow`=1, `out_count`=255.
  - The following vector (2,3,last) gives 6 with overflow 0.
- After beats (100,100), (50,50) assert `rst` for 2 cycles → all outputs 0 and `in_ready`=0 during reset. Then (10,10,last) → `out_sum`=100, `out_count`=1.
- Vector (0,200), idle 3 cycles, (7,0), (4,5,last) → `out_sum`=20, `out_count`=3.
